// File: rtl/gtx_tx_sched.sv
// rtl/gtx_tx_sched.sv - round-robin framed transmit scheduler for one 16-bit GTX TX lane
//
// Shares one 8b/10b TX lane among N_REQ requesters. Each granted burst is
// framed as SOF, data words, then EOF. A burst that reaches MAX_BURST words
// without a last flag is closed with the truncated EOF code. After every EOF
// at least MIN_GAP comma idles are sent. Every cycle that carries nothing
// else also carries a comma idle, which keeps the far end aligned.
//
// Ports:
//   clk_i           TX user clock (gt0_txusrclk2)
//   rst_i           asynchronous active-high reset
//   link_up_i       TX reset done, synchronous to clk_i
//   req_valid_i     per-requester data valid
//   req_last_i      per-requester last word of frame
//   req_data_i      per-requester data, requester k at [16k+15:16k]
//   req_ready_o     per-requester accept, one-hot to the granted requester
//   gt_txdata_o     registered lane word, byte [7:0] is sent first
//   gt_txcharisk_o  registered K flags, bit 0 qualifies [7:0]
//   busy_o          high whenever the scheduler is not in IDLE
//   frame_cnt_o     normal EOFs sent          (GTX_TX_SCHED_STATS_EN only)
//   trunc_cnt_o     truncated EOFs sent       (GTX_TX_SCHED_STATS_EN only)
//   abort_cnt_o     frames aborted by link drop (GTX_TX_SCHED_STATS_EN only)
//
// Optional macro: GTX_TX_SCHED_STATS_EN adds the three wrapping statistics counters.

module gtx_tx_sched #(
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 64,
    parameter int MIN_GAP   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 link_up_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ-1:0]     req_last_i,
    input  logic [16*N_REQ-1:0]  req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [15:0]          gt_txdata_o,
    output logic [1:0]           gt_txcharisk_o,
`ifdef GTX_TX_SCHED_STATS_EN
    output logic [15:0]          frame_cnt_o,
    output logic [15:0]          trunc_cnt_o,
    output logic [15:0]          abort_cnt_o,
`endif
    output logic                 busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [15:0] IDLE_WORD  = 16'h50BC;
    localparam logic [1:0]  IDLE_K     = 2'b01;
    localparam logic [15:0] EOF_WORD   = 16'hBCFD;
    localparam logic [15:0] TRUNC_WORD = 16'hBCFE;
    localparam logic [1:0]  EOF_K      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_EOF,
        ST_GAP
    } state_t;

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   grant_q, grant_n;
    logic [IDX_W-1:0]   rr_q, rr_n;
    logic [CNT_W-1:0]   burst_q, burst_n;
    logic [3:0]         gap_q, gap_n;
    logic               trunc_q, trunc_n;
    logic [15:0]        txdata_q, txdata_n;
    logic [1:0]         txk_q, txk_n;

    // Round-robin search: walking offsets from high to low lets the lowest
    // offset from the pointer overwrite any later candidate.
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   probe;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        probe = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            probe = IDX_W'((int'(rr_q) + i) % N_REQ);
            if (req_valid_i[probe]) begin
                found = 1'b1;
                pick  = probe;
            end
        end
    end

    // Granted requester's stream, selected with constant slices only.
    logic        sel_valid;
    logic        sel_last;
    logic [15:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q == IDX_W'(k)) begin
                sel_valid = req_valid_i[k];
                sel_last  = req_last_i[k];
                sel_data  = req_data_i[16*k +: 16];
            end
        end
    end

    // Ready is gated by link_up_i so no word is handshaken on the cycle the
    // frame is being aborted.
    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready_o[k] = (state_q == ST_DATA) && link_up_i && (grant_q == IDX_W'(k));
        end
    end

    always_comb begin
        state_n  = state_q;
        grant_n  = grant_q;
        rr_n     = rr_q;
        burst_n  = burst_q;
        gap_n    = gap_q;
        trunc_n  = trunc_q;
        txdata_n = IDLE_WORD;
        txk_n    = IDLE_K;

        if (!link_up_i) begin
            // Abort without EOF; the round-robin pointer survives.
            state_n = ST_IDLE;
            burst_n = '0;
            gap_n   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        grant_n  = pick;
                        rr_n     = IDX_W'((int'(pick) + 1) % N_REQ);
                        burst_n  = '0;
                        txdata_n = {{(8-IDX_W){1'b0}}, pick, 8'hFB};
                        txk_n    = 2'b01;
                        state_n  = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // A stalled requester leaves an in-frame idle bubble.
                    if (sel_valid) begin
                        txdata_n = sel_data;
                        txk_n    = 2'b00;
                        burst_n  = burst_q + 1'b1;
                        if (sel_last) begin
                            trunc_n = 1'b0;
                            state_n = ST_EOF;
                        end else if (burst_q == CNT_W'(MAX_BURST - 1)) begin
                            trunc_n = 1'b1;
                            state_n = ST_EOF;
                        end
                    end
                end
                ST_EOF: begin
                    txdata_n = trunc_q ? TRUNC_WORD : EOF_WORD;
                    txk_n    = EOF_K;
                    burst_n  = '0;
                    gap_n    = '0;
                    state_n  = ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == 4'(MIN_GAP - 1)) begin
                        gap_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        gap_n = gap_q + 4'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            burst_q  <= '0;
            gap_q    <= '0;
            trunc_q  <= 1'b0;
            txdata_q <= IDLE_WORD;
            txk_q    <= IDLE_K;
        end else begin
            state_q  <= state_n;
            grant_q  <= grant_n;
            rr_q     <= rr_n;
            burst_q  <= burst_n;
            gap_q    <= gap_n;
            trunc_q  <= trunc_n;
            txdata_q <= txdata_n;
            txk_q    <= txk_n;
        end
    end

    assign gt_txdata_o    = txdata_q;
    assign gt_txcharisk_o = txk_q;
    assign busy_o         = (state_q != ST_IDLE);

`ifdef GTX_TX_SCHED_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] trunc_cnt_q;
    logic [15:0] abort_cnt_q;

    // EOF codes are counted on the edge that registers them; an abort is a
    // link drop while a frame has started but its EOF has not been sent.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (!link_up_i && (state_q == ST_DATA || state_q == ST_EOF)) begin
                abort_cnt_q <= abort_cnt_q + 16'd1;
            end
            if (link_up_i && state_q == ST_EOF) begin
                if (trunc_q) begin
                    trunc_cnt_q <= trunc_cnt_q + 16'd1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
            end
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign trunc_cnt_o = trunc_cnt_q;
    assign abort_cnt_o = abort_cnt_q;
`endif

endmodule

// File: tb/tb_gtx_tx_sched.sv
// tb/tb_gtx_tx_sched.sv - self-checking bench for gtx_tx_sched
module tb_gtx_tx_sched;

    localparam int N  = 3;
    localparam int MB = 4;
    localparam int MG = 2;

    localparam logic [15:0] IDL  = 16'h50BC;
    localparam logic [15:0] SOF0 = 16'h00FB;
    localparam logic [15:0] SOF1 = 16'h01FB;
    localparam logic [15:0] EOFW = 16'hBCFD;
    localparam logic [15:0] TRW  = 16'hBCFE;

    logic            clk = 1'b0;
    logic            rst;
    logic            link;
    logic [N-1:0]    valid, last, ready;
    logic [16*N-1:0] data;
    logic [15:0]     txd;
    logic [1:0]      txk;
    logic            busy;
`ifdef GTX_TX_SCHED_STATS_EN
    logic [15:0]     fc, tc, ac;
`endif

    always #5 clk = ~clk;

    gtx_tx_sched #(.N_REQ(N), .MAX_BURST(MB), .MIN_GAP(MG)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .link_up_i      (link),
        .req_valid_i    (valid),
        .req_last_i     (last),
        .req_data_i     (data),
        .req_ready_o    (ready),
        .gt_txdata_o    (txd),
        .gt_txcharisk_o (txk),
`ifdef GTX_TX_SCHED_STATS_EN
        .frame_cnt_o    (fc),
        .trunc_cnt_o    (tc),
        .abort_cnt_o    (ac),
`endif
        .busy_o         (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent count of EOF codes seen on the lane.
    int eof_seen, trunc_seen;
    always @(negedge clk) begin
        if (rst) begin
            eof_seen   = 0;
            trunc_seen = 0;
        end else if (txk == 2'b11) begin
            if (txd == EOFW) eof_seen++;
            else if (txd == TRW) trunc_seen++;
        end
    end

    typedef struct {
        logic        lk;
        logic [2:0]  v;
        logic [2:0]  l;
        logic [15:0] d;
        logic [15:0] xd;
        logic [1:0]  xk;
        logic [2:0]  xr;
        logic        xb;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic [2:0] v, logic [2:0] l, logic [15:0] d,
                                logic [15:0] xd, logic [1:0] xk, logic [2:0] xr, logic xb);
        vec_t e;
        e.lk = 1'b1; e.v = v; e.l = l; e.d = d;
        e.xd = xd; e.xk = xk; e.xr = xr; e.xb = xb;
        tbl.push_back(e);
    endfunction

    typedef struct {
        logic [15:0] d;
        logic        l;
    } word_t;
    word_t src[N][$];
    int spos[N], ppos[N];
    logic [N-1:0] hs, prev_valid, exp_r;

    function automatic bit all_done();
        for (int k = 0; k < N; k++) if (ppos[k] != src[k].size()) return 1'b0;
        return 1'b1;
    endfunction

    int  sof_n, exp_id, cur_id, idle_run, cyc;
    bit  seen_eof, done;
    bit  in_frame, expect_eof, must_sof;
    int  cur, fcnt, rr_m, idle_since, id;
    logic [15:0] exp_code;

    initial begin
        // idle, 3-word frame, frame with bubbles (last coincides with MAX_BURST),
        // truncated frame followed by its continuation frame
        for (int i = 0; i < 4; i++) add(3'b000, 3'b000, 16'h0, IDL, 2'b01, 3'b000, 1'b0);
        add(3'b001, 3'b000, 16'hA001, IDL,   2'b01, 3'b000, 1'b0);
        add(3'b001, 3'b000, 16'hA001, SOF0,  2'b01, 3'b001, 1'b1);
        add(3'b001, 3'b000, 16'hA002, 16'hA001, 2'b00, 3'b001, 1'b1);
        add(3'b001, 3'b001, 16'hA003, 16'hA002, 2'b00, 3'b001, 1'b1);
        add(3'b000, 3'b000, 16'h0,    16'hA003, 2'b00, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    EOFW,  2'b11, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    IDL,   2'b01, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    IDL,   2'b01, 3'b000, 1'b0);
        add(3'b001, 3'b000, 16'hB001, IDL,   2'b01, 3'b000, 1'b0);
        add(3'b001, 3'b000, 16'hB001, SOF0,  2'b01, 3'b001, 1'b1);
        add(3'b000, 3'b000, 16'h0,    16'hB001, 2'b00, 3'b001, 1'b1);
        add(3'b000, 3'b000, 16'h0,    IDL,   2'b01, 3'b001, 1'b1);
        add(3'b001, 3'b000, 16'hB002, IDL,   2'b01, 3'b001, 1'b1);
        add(3'b001, 3'b000, 16'hB003, 16'hB002, 2'b00, 3'b001, 1'b1);
        add(3'b001, 3'b001, 16'hB004, 16'hB003, 2'b00, 3'b001, 1'b1);
        add(3'b000, 3'b000, 16'h0,    16'hB004, 2'b00, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    EOFW,  2'b11, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    IDL,   2'b01, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    IDL,   2'b01, 3'b000, 1'b0);
        add(3'b010, 3'b000, 16'hC001, IDL,   2'b01, 3'b000, 1'b0);
        add(3'b010, 3'b000, 16'hC001, SOF1,  2'b01, 3'b010, 1'b1);
        add(3'b010, 3'b000, 16'hC002, 16'hC001, 2'b00, 3'b010, 1'b1);
        add(3'b010, 3'b000, 16'hC003, 16'hC002, 2'b00, 3'b010, 1'b1);
        add(3'b010, 3'b000, 16'hC004, 16'hC003, 2'b00, 3'b010, 1'b1);
        add(3'b010, 3'b000, 16'hC005, 16'hC004, 2'b00, 3'b000, 1'b1);
        add(3'b010, 3'b000, 16'hC005, TRW,   2'b11, 3'b000, 1'b1);
        add(3'b010, 3'b000, 16'hC005, IDL,   2'b01, 3'b000, 1'b1);
        add(3'b010, 3'b000, 16'hC005, IDL,   2'b01, 3'b000, 1'b0);
        add(3'b010, 3'b000, 16'hC005, SOF1,  2'b01, 3'b010, 1'b1);
        add(3'b010, 3'b010, 16'hC006, 16'hC005, 2'b00, 3'b010, 1'b1);
        add(3'b000, 3'b000, 16'h0,    16'hC006, 2'b00, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    EOFW,  2'b11, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    IDL,   2'b01, 3'b000, 1'b1);
        add(3'b000, 3'b000, 16'h0,    IDL,   2'b01, 3'b000, 1'b0);

        rst = 1'b1; link = 1'b0; valid = '0; last = '0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", txd, IDL);
        chk("rst_k", txk, 2'b01);
        chk("rst_ready", ready, 3'b000);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            link = tbl[i].lk; valid = tbl[i].v; last = tbl[i].l; data = {N{tbl[i].d}};
            @(negedge clk);
            chk($sformatf("vec%0d_data", i), txd, tbl[i].xd);
            chk($sformatf("vec%0d_k", i), txk, tbl[i].xk);
            chk($sformatf("vec%0d_ready", i), ready, tbl[i].xr);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].xb);
        end

        // Two requesters with single-word frames: grants alternate, gap exact.
        sof_n = 0; exp_id = 0; cur_id = 0; idle_run = 0; cyc = 0; seen_eof = 0; done = 0;
        @(posedge clk); #1;
        valid = 3'b011; last = 3'b011; data = {16'hD002, 16'hD001, 16'hD000};
        while (!done && cyc < 120) begin
            @(negedge clk); cyc++;
            if (txk == 2'b01 && txd[7:0] == 8'hFB) begin
                chk("alt_id", txd[15:8], exp_id);
                if (seen_eof) chk("alt_gap", idle_run, MG);
                cur_id = exp_id; exp_id = 1 - exp_id; sof_n++;
            end else if (txk == 2'b00) begin
                chk("alt_data", txd, 16'(16'hD000 + cur_id));
            end else if (txk == 2'b11) begin
                chk("alt_eof", txd, EOFW);
                seen_eof = 1; idle_run = 0;
                if (sof_n >= 8) begin
                    @(posedge clk); #1 valid = '0;
                    done = 1;
                end
            end else begin
                idle_run++;
            end
        end
        chk("alt_done", done, 1'b1);

        // Link drop on the second data word of a req0 frame.
        repeat (4) @(posedge clk);
        #1 valid = 3'b001; last = '0; data = {N{16'hE001}};
        @(negedge clk); chk("ld_idle", txd, IDL);
        @(posedge clk); #1;
        @(negedge clk); chk("ld_sof", txd, SOF0); chk("ld_sof_ready", ready, 3'b001);
        @(posedge clk); #1 data = {N{16'hE002}}; link = 1'b0;
        @(negedge clk); chk("ld_word", txd, 16'hE001);
        @(posedge clk); #1 link = 1'b1; valid = '0;
        @(negedge clk);
        chk("ld_abort_data", txd, IDL);
        chk("ld_abort_k", txk, 2'b01);
        chk("ld_abort_ready", ready, 3'b000);
        chk("ld_abort_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("ld_no_eof", txk == 2'b11, 1'b0);
        end
`ifdef GTX_TX_SCHED_STATS_EN
        chk("st_abort", ac, 16'd1);
        chk("st_trunc", tc, 16'd1);
        chk("st_frame", fc, 16'(eof_seen));
`endif

        // Randomized traffic against a frame-level reference model.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            src[k].delete();
            spos[k] = 0; ppos[k] = 0;
            for (int j = 0; j < 20; j++) begin
                word_t w;
                w.d = 16'($urandom);
                w.l = ($urandom_range(0, 3) == 0) || (j == 19);
                src[k].push_back(w);
            end
        end
        hs = '0; prev_valid = '0; rr_m = 0; in_frame = 0; expect_eof = 0; must_sof = 0;
        cur = 0; fcnt = 0; idle_since = MG; exp_code = EOFW; cyc = 0;
        while (cyc < 4000 && !(all_done() && !in_frame)) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (hs[k]) spos[k]++;
                if (spos[k] < src[k].size() && $urandom_range(0, 9) < 7) begin
                    valid[k] = 1'b1;
                    data[16*k +: 16] = src[k][spos[k]].d;
                    last[k] = src[k][spos[k]].l;
                end else begin
                    valid[k] = 1'b0;
                    data[16*k +: 16] = 16'($urandom);
                    last[k] = 1'($urandom);
                end
            end
            @(negedge clk); cyc++;
            if (must_sof) chk("rnd_sof_due", (txk == 2'b01) && (txd[7:0] == 8'hFB), 1'b1);
            if (txk == 2'b01 && txd[7:0] == 8'hFB) begin
                chk("rnd_sof_outside", in_frame, 1'b0);
                chk("rnd_sof_gap", idle_since >= MG, 1'b1);
                id = -1;
                for (int i = 0; i < N; i++) begin
                    if (id < 0 && prev_valid[(rr_m + i) % N]) id = (rr_m + i) % N;
                end
                chk("rnd_sof_id", txd[15:8], id);
                cur = txd[15:8] % N; rr_m = (cur + 1) % N;
                in_frame = 1; fcnt = 0; expect_eof = 0;
            end else if (txk == 2'b01 && txd == IDL) begin
                if (in_frame) chk("rnd_eof_late", expect_eof, 1'b0);
                else idle_since++;
            end else if (txk == 2'b00) begin
                chk("rnd_data_inframe", in_frame && !expect_eof, 1'b1);
                if (ppos[cur] < src[cur].size()) begin
                    chk("rnd_data", txd, src[cur][ppos[cur]].d);
                    fcnt++;
                    if (src[cur][ppos[cur]].l) begin
                        expect_eof = 1; exp_code = EOFW;
                    end else if (fcnt == MB) begin
                        expect_eof = 1; exp_code = TRW;
                    end
                    ppos[cur]++;
                end else begin
                    chk("rnd_data_extra", ppos[cur], src[cur].size() - 1);
                end
            end else if (txk == 2'b11) begin
                chk("rnd_eof_due", in_frame && expect_eof, 1'b1);
                chk("rnd_eof_code", txd, exp_code);
                in_frame = 0; expect_eof = 0; idle_since = 0;
            end else begin
                chk("rnd_bad_word", {14'h0, txk, txd}, {14'h0, 2'b01, IDL});
            end
            exp_r = (in_frame && !expect_eof) ? (N'(1) << cur) : '0;
            chk("rnd_ready", ready, exp_r);
            must_sof = !in_frame && (idle_since >= MG) && (txd == IDL) && (valid != '0);
            prev_valid = valid;
            hs = valid & ready;
        end
        for (int k = 0; k < N; k++) chk($sformatf("rnd_consumed%0d", k), ppos[k], src[k].size());
        chk("rnd_closed", in_frame, 1'b0);
        @(posedge clk); #1;
`ifdef GTX_TX_SCHED_STATS_EN
        chk("rnd_st_frame", fc, 16'(eof_seen));
        chk("rnd_st_trunc", tc, 16'(trunc_seen));
        chk("rnd_st_abort", ac, 16'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
